// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the mips32_pipe_fwd pipeline.
//   - opcode constants and the instruction-class enum used for decode
//   - forwarding select enum driven by the hazard unit
//   - per-stage pipeline register structs (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   - small decode helpers (class, source-register usage)
package mips_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_SLTI  = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D;
    localparam logic [5:0] OP_BEQZ  = 6'h0E;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    // Opcode 3E is unassigned, so this word decodes as a retiring NOP.
    localparam logic [31:0] NOP_IR = 32'hF800_0000;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} iclass_t;
    typedef enum logic [1:0] {FWD_REG, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    // dst is 0 for instructions that write no register, so a single
    // compare against dst covers both "is a producer" and "which register".
    typedef struct packed {
        logic        valid;
        iclass_t     cls;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        iclass_t     cls;
        logic [4:0]  dst;
        logic [31:0] alu_out;
        logic [31:0] b;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        iclass_t     cls;
        logic [4:0]  dst;
        logic [31:0] alu_out;
    } mem_wb_t;

    function automatic iclass_t classify(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

    function automatic logic uses_rs(input iclass_t c);
        return c inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
    endfunction

    function automatic logic uses_rt(input iclass_t c);
        return c inside {RR_ALU, STORE};
    endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit: combinational hazard control for mips32_pipe_fwd.
// Inputs : valid/class/register fields of the ID, EX, MEM and WB stages,
//          and br_taken (resolved branch in EX).
// Outputs: fwd_a/fwd_b   EX operand source selects for rs/rt
//          stall         hold PC and IF/ID, inject a bubble into EX
//          flush         squash IF/ID and ID/EX (taken branch)
//          fetch_hold    a HLT is in flight; stop fetching
module mips_hazard_unit
    import mips_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic       id_valid,
    input  iclass_t    id_cls,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  iclass_t    ex_cls,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_dst,
    input  logic       br_taken,
    input  logic       mem_valid,
    input  iclass_t    mem_cls,
    input  logic [4:0] mem_dst,
    input  logic       wb_valid,
    input  iclass_t    wb_cls,
    input  logic [4:0] wb_dst,
    output fwd_sel_t   fwd_a,
    output fwd_sel_t   fwd_b,
    output logic       stall,
    output logic       flush,
    output logic       fetch_hold
);

    // Youngest producer wins. A load in EX/MEM has only its address, never
    // its data; the load-use stall guarantees no consumer needs it there.
    function automatic fwd_sel_t pick(input logic [4:0] src);
        if (!FORWARD_EN || src == 5'd0)                      return FWD_REG;
        if (mem_valid && mem_cls != LOAD && mem_dst == src)  return FWD_EXMEM;
        if (wb_valid && wb_dst == src)                       return FWD_MEMWB;
        return FWD_REG;
    endfunction

    function automatic logic id_hit(input logic [4:0] dst);
        return id_valid && dst != 5'd0 &&
               ((uses_rs(id_cls) && dst == id_rs) || (uses_rt(id_cls) && dst == id_rt));
    endfunction

    logic raw_stall;

    always_comb begin
        fwd_a = pick(ex_rs);
        fwd_b = pick(ex_rt);
        // WB producers never stall: the register file is write-first.
        if (FORWARD_EN)
            raw_stall = ex_valid && ex_cls == LOAD && id_hit(ex_dst);
        else
            raw_stall = (ex_valid && id_hit(ex_dst)) || (mem_valid && id_hit(mem_dst));
        flush      = br_taken;
        stall      = raw_stall && !br_taken;
        fetch_hold = (id_valid && id_cls == HALT) || (ex_valid && ex_cls == HALT) ||
                     (mem_valid && mem_cls == HALT) || (wb_valid && wb_cls == HALT);
    end

endmodule

// File: rtl/mips32_pipe_fwd.sv
// mips32_pipe_fwd: 5-stage MIPS32 pipeline (IF/ID/EX/MEM/WB) with forwarding
// or interlock, load-use stall, branch flush in EX and HLT handling.
// Ports:
//   clk            pipeline clock, rising edge
//   rst            asynchronous active-high reset
//   halted         set when HLT retires; sticky until reset
//   pc             current fetch PC
//   instr_retired  valid instructions reaching WB (including HLT)
//   stall_cycles   cycles the PC was held for a data hazard
// Reg (32x32) and Mem (MEM_DEPTH words) are plain arrays, not reset.
module mips32_pipe_fwd
    import mips_pkg::*;
#(
    parameter int          MEM_DEPTH  = 1024,
    parameter bit          FORWARD_EN = 1'b1,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             halted,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] Reg [32];
    logic [31:0] Mem [MEM_DEPTH];

    if_id_t  if_id;
    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    function automatic logic [AW-1:0] maddr(input logic [31:0] v);
        return AW'(v % MEM_DEPTH);
    endfunction

    iclass_t            id_cls;
    logic [4:0]         id_rs, id_rt, id_dst;
    logic [31:0]        id_imm, id_a, id_b, mem_rdata, mem_res, br_target;
    logic signed [31:0] op_a, op_b, alu_b;
    logic [31:0]        ex_res;
    logic               br_taken, wb_we;
    fwd_sel_t           fwd_a, fwd_b;
    logic               stall, flush, fetch_hold;

    assign wb_we = mem_wb.valid && mem_wb.dst != 5'd0 && !halted;

    // ---- ID: decode and write-first register read ----
    always_comb begin
        id_cls = classify(if_id.ir[31:26]);
        id_rs  = if_id.ir[25:21];
        id_rt  = if_id.ir[20:16];
        id_imm = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
        case (id_cls)
            RR_ALU:       id_dst = if_id.ir[15:11];
            RM_ALU, LOAD: id_dst = id_rt;
            default:      id_dst = 5'd0;
        endcase
        id_a = (id_rs == 5'd0) ? 32'd0 :
               (wb_we && mem_wb.dst == id_rs) ? mem_wb.alu_out : Reg[id_rs];
        id_b = (id_rt == 5'd0) ? 32'd0 :
               (wb_we && mem_wb.dst == id_rt) ? mem_wb.alu_out : Reg[id_rt];
    end

    // ---- EX: operand forwarding, ALU, branch resolution ----
    always_comb begin
        case (fwd_a)
            FWD_EXMEM: op_a = ex_mem.alu_out;
            FWD_MEMWB: op_a = mem_wb.alu_out;
            default:   op_a = id_ex.a;
        endcase
        case (fwd_b)
            FWD_EXMEM: op_b = ex_mem.alu_out;
            FWD_MEMWB: op_b = mem_wb.alu_out;
            default:   op_b = id_ex.b;
        endcase
        alu_b = (id_ex.cls == RR_ALU) ? op_b : id_ex.imm;
        case (id_ex.op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_res = op_a + alu_b;
            OP_SUB, OP_SUBI:               ex_res = op_a - alu_b;
            OP_AND:                        ex_res = op_a & alu_b;
            OP_OR:                         ex_res = op_a | alu_b;
            OP_SLT, OP_SLTI:               ex_res = {31'd0, op_a < alu_b};
            OP_MUL:                        ex_res = op_a * alu_b;
            default:                       ex_res = 32'd0;
        endcase
        br_target = id_ex.npc + id_ex.imm;
        br_taken  = id_ex.valid && id_ex.cls == BRANCH &&
                    ((id_ex.op == OP_BEQZ) ? (op_a == '0) : (op_a != '0));
    end

    // ---- MEM: load data replaces the address on its way to WB ----
    assign mem_rdata = Mem[maddr(ex_mem.alu_out)];
    assign mem_res   = (ex_mem.cls == LOAD) ? mem_rdata : ex_mem.alu_out;

    mips_hazard_unit #(.FORWARD_EN(FORWARD_EN)) u_hazard (
        .id_valid  (if_id.valid),
        .id_cls    (id_cls),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .ex_valid  (id_ex.valid),
        .ex_cls    (id_ex.cls),
        .ex_rs     (id_ex.rs),
        .ex_rt     (id_ex.rt),
        .ex_dst    (id_ex.dst),
        .br_taken  (br_taken),
        .mem_valid (ex_mem.valid),
        .mem_cls   (ex_mem.cls),
        .mem_dst   (ex_mem.dst),
        .wb_valid  (mem_wb.valid),
        .wb_cls    (mem_wb.cls),
        .wb_dst    (mem_wb.dst),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .stall     (stall),
        .flush     (flush),
        .fetch_hold(fetch_hold)
    );

    // Only valid bits, PC, counters and halted are reset; everything else
    // is qualified by valid. Once halted, the whole pipeline freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            halted        <= 1'b0;
            instr_retired <= '0;
            stall_cycles  <= '0;
            if_id.valid   <= 1'b0;
            id_ex.valid   <= 1'b0;
            ex_mem.valid  <= 1'b0;
            mem_wb.valid  <= 1'b0;
        end else if (!halted) begin
            // ---- WB: retire ----
            if (mem_wb.valid) begin
                instr_retired <= instr_retired + 1'b1;
                if (mem_wb.cls == HALT) halted <= 1'b1;
            end
            if (stall) stall_cycles <= stall_cycles + 1'b1;

            // ---- IF: flush beats stall, stall beats HLT fetch hold ----
            if (flush)                        pc <= br_target;
            else if (!stall && !fetch_hold)   pc <= pc + 32'd1;

            if (flush || (!stall && fetch_hold))
                if_id <= '{valid: 1'b0, ir: NOP_IR, npc: pc};
            else if (!stall)
                if_id <= '{valid: 1'b1, ir: Mem[maddr(pc)], npc: pc + 32'd1};

            // ---- ID -> EX ----
            if (flush || stall)
                id_ex.valid <= 1'b0;
            else
                id_ex <= '{valid: if_id.valid, cls: id_cls, op: if_id.ir[31:26],
                           rs: id_rs, rt: id_rt, dst: id_dst, npc: if_id.npc,
                           a: id_a, b: id_b, imm: id_imm};

            // ---- EX -> MEM ----
            ex_mem <= '{valid: id_ex.valid, cls: id_ex.cls, dst: id_ex.dst,
                        alu_out: ex_res, b: op_b};

            // ---- MEM -> WB ----
            mem_wb <= '{valid: ex_mem.valid, cls: ex_mem.cls, dst: ex_mem.dst,
                        alu_out: mem_res};
        end
    end

    // Architectural state writes; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && !halted) begin
            if (wb_we) Reg[mem_wb.dst] <= mem_wb.alu_out;
            if (ex_mem.valid && ex_mem.cls == STORE)
                Mem[maddr(ex_mem.alu_out)] <= ex_mem.b;
        end
    end

endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// tb_mips32_pipe_fwd: directed programs run on a forwarding core (dut) and
// an interlock core (dut_il) side by side, with hand-computed results.
module tb_mips32_pipe_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        halted_f, halted_i;
    logic [31:0] pc_f, pc_i, ret_f, ret_i, stl_f, stl_i;

    always #5 clk = ~clk;

    mips32_pipe_fwd #(.MEM_DEPTH(1024), .FORWARD_EN(1), .RESET_PC(0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .halted(halted_f), .pc(pc_f),
        .instr_retired(ret_f), .stall_cycles(stl_f)
    );

    mips32_pipe_fwd #(.MEM_DEPTH(1024), .FORWARD_EN(0), .RESET_PC(0), .CNT_W(32)) dut_il (
        .clk(clk), .rst(rst), .halted(halted_i), .pc(pc_i),
        .instr_retired(ret_i), .stall_cycles(stl_i)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] prog [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // Called with rst held high so neither core writes its arrays meanwhile.
    task automatic load();
        for (int i = 0; i < 1024; i++) begin
            dut.Mem[i]    = 32'd0;
            dut_il.Mem[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) begin
            dut.Reg[i]    = 32'd0;
            dut_il.Reg[i] = 32'd0;
        end
        foreach (prog[i]) begin
            dut.Mem[i]    = prog[i];
            dut_il.Mem[i] = prog[i];
        end
    endtask

    task automatic run(input string tag);
        int n = 0;
        @(negedge clk);
        rst = 1'b0;
        while (!(halted_f && halted_i) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, {31'd0, halted_f & halted_i}, 32'd1);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        #12;
        check("rst_pc", pc_f, 32'd0);
        check("rst_halted", {31'd0, halted_f}, 32'd0);
        check("rst_retired", ret_f, 32'd0);
        check("rst_stalls", stl_f, 32'd0);

        // Dependent ALU chain with no filler instructions.
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000,
                 32'h00832800, 32'hfc000000};
        load();
        run("t1");
        check("t1_r4", dut.Reg[4], 32'd30);
        check("t1_r5", dut.Reg[5], 32'd55);
        check("t1_retired", ret_f, 32'd6);
        check("t1_stalls", stl_f, 32'd0);
        check("t1_pc", pc_f, 32'd6);
        check("t2_r4", dut_il.Reg[4], 32'd30);
        check("t2_r5", dut_il.Reg[5], 32'd55);
        check("t2_retired", ret_i, 32'd6);
        check("t2_stalls", stl_i, 32'd3);

        // Load-use followed by a store of the forwarded sum.
        enter_reset();
        check("rst_clears_halted", {31'd0, halted_f}, 32'd0);
        prog = '{32'h280a0078, 32'h21420000, 32'h2842002d, 32'h25420001, 32'hfc000000};
        load();
        dut.Mem[120]    = 32'd85;
        dut_il.Mem[120] = 32'd85;
        run("t3");
        check("t3_mem121", dut.Mem[121], 32'd130);
        check("t3_r2", dut.Reg[2], 32'd130);
        check("t3_stalls", stl_f, 32'd1);
        check("t3_retired", ret_f, 32'd5);
        check("t3_il_mem121", dut_il.Mem[121], 32'd130);

        // Countdown loop: two taken branches.
        enter_reset();
        prog = '{32'h28010003, 32'h2c210001, 32'h3420fffe, 32'hfc000000};
        load();
        run("t4");
        check("t4_r1", dut.Reg[1], 32'd0);
        check("t4_retired", ret_f, 32'd8);
        check("t4_stalls", stl_f, 32'd0);
        check("t4_pc", pc_f, 32'd4);
        check("t4_il_r1", dut_il.Reg[1], 32'd0);
        check("t4_il_retired", ret_i, 32'd8);

        // HLT in the shadow of a taken branch must be discarded.
        enter_reset();
        prog = '{32'h38000001, 32'hfc000000, 32'h28050007, 32'hfc000000};
        load();
        run("t5");
        check("t5_r5", dut.Reg[5], 32'd7);
        check("t5_retired", ret_f, 32'd3);
        check("t5_pc", pc_f, 32'd4);
        check("t5_il_r5", dut_il.Reg[5], 32'd7);

        // Reset in the middle of the loop, then rerun.
        enter_reset();
        prog = '{32'h28010003, 32'h2c210001, 32'h3420fffe, 32'hfc000000};
        load();
        dut.Reg[7]    = 32'h1234;
        dut_il.Reg[7] = 32'h1234;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_pre_retired", ret_f, 32'd3);
        rst = 1'b1;
        #1;
        check("t6_async_pc", pc_f, 32'd0);
        check("t6_async_retired", ret_f, 32'd0);
        check("t6_async_stalls", stl_f, 32'd0);
        check("t6_async_halted", {31'd0, halted_f}, 32'd0);
        run("t6");
        check("t6_r1", dut.Reg[1], 32'd0);
        check("t6_retired", ret_f, 32'd8);
        check("t6_r7_kept", dut.Reg[7], 32'h1234);
        check("t6_il_r1", dut_il.Reg[1], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
